swc_display: RTL and testbench

SWC_DISPLAY -- requirements
Module: swc_display

---
 rtl/swc_display.sv | 182 ++++++++++++++++++
 tb/tb_swc_display.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/swc_display.sv
// -----------------------------------------------------------------------------
// swc_display -- six-digit multiplexed seven-segment driver for the Swc
// stopwatch value.
//
// The 24-bit counter is shown as six hex digits, one digit slot of ScanDiv
// clock cycles at a time. counter/ready are captured only at the end of a
// frame (last cycle of slot 5), so every frame shows one coherent value.
// All outputs are registered and inactive (high) during reset.
//
// Parameters:
//   ScanDiv   clock cycles per digit slot (2..65535)
//   LeadBlank 1 = blank leading-zero digits (digit 0 always shown)
//
// Ports:
//   clock    sole clock, rising edge
//   reset    asynchronous, active-high reset
//   counter  stopwatch value (six hex nibbles)
//   ready    ready flag, shown on the digit-0 decimal point
//   seg      segments a..g on seg[0]..seg[6], active-low
//   dp       decimal point, active-low
//   an       digit enables, active-low; an[k] shows counter nibble k
// -----------------------------------------------------------------------------
module swc_display #(
   parameter int unsigned ScanDiv   = 4,
   parameter bit          LeadBlank = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [23:0] counter,
   input  logic        ready,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [5:0]  an
);

   localparam int unsigned     PreW    = (ScanDiv > 2) ? $clog2(ScanDiv) : 1;
   localparam logic [PreW-1:0] PreLast = PreW'(ScanDiv - 1);

   logic [PreW-1:0] pre_q, pre_d;
   logic [2:0]      idx_q, idx_d;
   logic [23:0]     snap_q, snap_d;
   logic            rdy_s_q, rdy_s_d;

   logic [6:0]      seg_d;
   logic            dp_d;
   logic [5:0]      an_d;

   logic            pre_last;
   logic            frame_wrap;
   logic [3:0]      cur_nib;
   logic [5:0]      cur_sel;
   logic [5:0]      upper_zero;
   logic            cur_blank;
   logic            cur_en;

   function automatic logic [6:0] hex_font(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Scan timing and frame-wrap snapshot
   always_comb begin
      pre_last   = (pre_q == PreLast);
      frame_wrap = pre_last && (idx_q == 3'd5);

      pre_d = pre_last ? '0 : pre_q + 1'b1;

      idx_d = idx_q;
      if (pre_last) begin
         idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end

      snap_d  = snap_q;
      rdy_s_d = rdy_s_q;
      if (frame_wrap) begin
         snap_d  = counter;
         rdy_s_d = ready;
      end
   end

   // upper_zero[k]: nibbles 5..k of the snapshot are all zero
   always_comb begin
      upper_zero    = '0;
      upper_zero[5] = (snap_q[23:20] == 4'h0);
      upper_zero[4] = upper_zero[5] && (snap_q[19:16] == 4'h0);
      upper_zero[3] = upper_zero[4] && (snap_q[15:12] == 4'h0);
      upper_zero[2] = upper_zero[3] && (snap_q[11:8]  == 4'h0);
      upper_zero[1] = upper_zero[2] && (snap_q[7:4]   == 4'h0);
      upper_zero[0] = upper_zero[1] && (snap_q[3:0]   == 4'h0);
   end

   // Digit selection and output next-state
   always_comb begin
      cur_nib   = snap_q[3:0];
      cur_sel   = 6'h3E;
      cur_blank = 1'b0;
      case (idx_q)
         3'd0: begin
            cur_nib = snap_q[3:0];
            cur_sel = 6'h3E;
         end
         3'd1: begin
            cur_nib   = snap_q[7:4];
            cur_sel   = 6'h3D;
            cur_blank = upper_zero[1];
         end
         3'd2: begin
            cur_nib   = snap_q[11:8];
            cur_sel   = 6'h3B;
            cur_blank = upper_zero[2];
         end
         3'd3: begin
            cur_nib   = snap_q[15:12];
            cur_sel   = 6'h37;
            cur_blank = upper_zero[3];
         end
         3'd4: begin
            cur_nib   = snap_q[19:16];
            cur_sel   = 6'h2F;
            cur_blank = upper_zero[4];
         end
         3'd5: begin
            cur_nib   = snap_q[23:20];
            cur_sel   = 6'h1F;
            cur_blank = upper_zero[5];
         end
         default: begin
            cur_nib   = 4'h0;
            cur_sel   = 6'h3F;
            cur_blank = 1'b1;
         end
      endcase
      // Digit 0 is never blanked so a zero value still shows "0"
      cur_blank = cur_blank && LeadBlank;

      // First cycle of each slot is dark to avoid ghosting between digits
      cur_en = (pre_q != '0) && !cur_blank;

      an_d  = cur_en ? cur_sel : 6'h3F;
      seg_d = cur_blank ? 7'h7F : hex_font(cur_nib);
      dp_d  = !(cur_en && (idx_q == 3'd0) && rdy_s_q);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pre_q   <= '0;
         idx_q   <= 3'd0;
         snap_q  <= 24'h000000;
         rdy_s_q <= 1'b0;
         an      <= 6'h3F;
         seg     <= 7'h7F;
         dp      <= 1'b1;
      end else begin
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         rdy_s_q <= rdy_s_d;
         an      <= an_d;
         seg     <= seg_d;
         dp      <= dp_d;
      end
   end

endmodule

// File: tb/tb_swc_display.sv
module tb_swc_display;

   logic        clock = 1'b0;
   logic        reset;
   logic [23:0] counter;
   logic        ready;

   logic [6:0]  seg0, seg1, seg2;
   logic        dp0, dp1, dp2;
   logic [5:0]  an0, an1, an2;

   always #5 clock = ~clock;

   swc_display #(.ScanDiv(4), .LeadBlank(1'b1)) dut0 (
      .clock(clock), .reset(reset), .counter(counter), .ready(ready),
      .seg(seg0), .dp(dp0), .an(an0)
   );
   swc_display #(.ScanDiv(4), .LeadBlank(1'b0)) dut1 (
      .clock(clock), .reset(reset), .counter(counter), .ready(ready),
      .seg(seg1), .dp(dp1), .an(an1)
   );
   swc_display #(.ScanDiv(2), .LeadBlank(1'b1)) dut2 (
      .clock(clock), .reset(reset), .counter(counter), .ready(ready),
      .seg(seg2), .dp(dp2), .an(an2)
   );

   int nvec    = 0;
   int nerr    = 0;
   int n       = 0;   // rising edges since reset released
   int phase   = 0;
   bit rst_evt = 1'b0;
   int en_cnt  = 0;

   logic [24:0] hist [int];   // {ready, counter} present at edge n
   logic [6:0]  font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [6:0]  p2_seg [6] = '{7'h0E, 7'h12, 7'h40, 7'h08, 7'h79, 7'h0E};
   logic [5:0]  p2_an  [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s (edge %0d, phase %0d): got %h, expected %h", name, n, phase, act, exp);
      end
   endtask

   // Expected {an, seg, dp} after edge nn, from elapsed-cycle arithmetic
   function automatic logic [13:0] model(input int d, input bit lb, input int nn);
      int s, pre, idx, f;
      logic [24:0] h;
      logic [23:0] sn;
      bit rd, blank, en;
      logic [5:0] a;
      logic [6:0] sg;
      if (nn == 0) return {6'h3F, 7'h7F, 1'b1};
      s   = nn - 1;
      pre = s % d;
      idx = (s / d) % 6;
      f   = s / (6 * d);
      h   = (f == 0) ? 25'd0 : hist[f * 6 * d];
      sn  = h[23:0];
      rd  = h[24];
      blank = lb && (idx != 0) && ((sn >> (4 * idx)) == 24'd0);
      en    = (pre != 0) && !blank;
      a  = en ? ~(6'd1 << idx) : 6'h3F;
      sg = blank ? 7'h7F : font[sn[4 * idx +: 4]];
      return {a, sg, !(en && idx == 0 && rd)};
   endfunction

   always @(posedge reset) rst_evt = 1'b1;

   // Compare process: every cycle, all three instances against the model
   always begin
      @(posedge clock);
      if (rst_evt) begin
         n       = 0;
         rst_evt = 1'b0;
      end
      if (reset) begin
         n      = 0;
         en_cnt = 0;
      end else begin
         n++;
         hist[n] = {ready, counter};
      end
      #1;
      check("model_d4_lb1", {18'd0, an0, seg0, dp0}, {18'd0, model(4, 1'b1, n)});
      check("model_d4_lb0", {18'd0, an1, seg1, dp1}, {18'd0, model(4, 1'b0, n)});
      check("model_d2_lb1", {18'd0, an2, seg2, dp2}, {18'd0, model(2, 1'b1, n)});

      if (phase == 1) begin
         if (n == 2)  check("zero_f0_digit0", {an0, seg0, dp0}, {6'h3E, 7'h40, 1'b1});
         if (n == 26) check("zero_f1_dp_low", {an0, seg0, dp0}, {6'h3E, 7'h40, 1'b0});
         if (n == 30) check("zero_f1_digit1_blank", {an0, seg0, dp0}, {6'h3F, 7'h7F, 1'b1});
      end
      if (phase == 2) begin
         for (int k = 0; k < 6; k++) begin
            if (n == 24 + 4 * k + 1) check("f1a05f_antighost", {26'd0, an0}, {26'd0, 6'h3F});
            if (n == 24 + 4 * k + 3) check("f1a05f_digit", {an0, seg0}, {p2_an[k], p2_seg[k]});
         end
      end
      if (phase == 3) begin
         if (n == 35) check("h100_lb1_digit2", {an0, seg0}, {6'h3B, 7'h79});
         if (n == 39) check("h100_lb1_digit3", {an0, seg0}, {6'h3F, 7'h7F});
         if (n == 39) check("h100_lb0_digit3", {an1, seg1}, {6'h37, 7'h40});
         if (n == 47) check("h100_lb0_digit5", {an1, seg1}, {6'h1F, 7'h40});
      end
      if (phase == 6 && n == 2) check("restart_digit0", {an0, seg0, dp0}, {6'h3E, 7'h40, 1'b1});
      if (phase == 7) begin
         if (n >= 13 && n <= 60 && an2 != 6'h3F) en_cnt++;
         if (n == 60) check("d2_enabled_cycles", en_cnt, 24);
      end
   end

   task automatic run(input int cycles, input bit rnd);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         if (rnd) begin
            counter = 24'($urandom);
            ready   = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic do_reset(input logic [23:0] c, input logic r, input int ph);
      @(negedge clock);
      reset   = 1'b1;
      counter = c;
      ready   = r;
      @(negedge clock);
      @(negedge clock);
      phase = ph;
      reset = 1'b0;
   endtask

   initial begin
      reset   = 1'b0;
      counter = 24'h000000;
      ready   = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      check("reset_outputs", {an0, seg0, dp0}, {6'h3F, 7'h7F, 1'b1});

      // Zero value with ready held from reset
      do_reset(24'h000000, 1'b1, 1);
      run(72, 1'b0);

      // Value applied during frame 0
      do_reset(24'h000000, 1'b0, 2);
      run(3, 1'b0);
      counter = 24'hF1A05F;
      run(60, 1'b0);

      // Leading-zero blanking on and off
      do_reset(24'h000100, 1'b0, 3);
      run(60, 1'b0);

      // Counter and ready changing every cycle
      do_reset(24'h000000, 1'b0, 4);
      run(288, 1'b1);

      // Short asynchronous reset pulse in slot 3
      do_reset(24'h000000, 1'b0, 5);
      for (int i = 0; i < 200 && n != 14; i++) run(1, 1'b1);
      check("reach_slot3", n, 14);
      phase = 6;
      reset = 1'b1;
      #1;
      check("pulse_async_d4", {an0, seg0, dp0}, {6'h3F, 7'h7F, 1'b1});
      check("pulse_async_d2", {an2, seg2, dp2}, {6'h3F, 7'h7F, 1'b1});
      #3;
      reset = 1'b0;
      run(100, 1'b1);

      // Constant value, no blanked digits, ScanDiv=2 frame period
      do_reset({1'b1, 23'($urandom)}, 1'($urandom_range(0, 1)), 7);
      run(64, 1'b0);

      @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
